// File: rtl/spi_rx_pkg.sv
// ---------------------------------------------------------------------------
// spi_rx_pkg
//
// Definitions shared by the SPI master receive and transmit paths.
//
// Contents:
//   - DEFAULT_DATA_LEN : default maximum word length in bits
//   - ST_IDLE/ST_RECV/ST_PUSH : one-hot receive FSM encodings
//   - ST_TFR/ST_STOP   : transmit-path names for the same one-hot codes, so
//                        both paths decode the same state bits
//   - state_idx_e      : bit position of each one-hot state
//   - entry_len_lsb()  : bit position where the length field starts inside a
//                        FIFO entry. Entries are packed {len, data}, with data
//                        right-aligned in the low DATA_LEN bits, so TX and RX
//                        entries have the same layout.
// ---------------------------------------------------------------------------
package spi_rx_pkg;

    localparam int DEFAULT_DATA_LEN = 32;

    // One-hot FSM encodings (receive path names)
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_RECV = 3'b010;
    localparam logic [2:0] ST_PUSH = 3'b100;

    // Transmit path uses the same codes under its own names
    localparam logic [2:0] ST_TFR  = ST_RECV;
    localparam logic [2:0] ST_STOP = ST_PUSH;

    typedef enum int unsigned {
        IDX_IDLE   = 0,
        IDX_ACTIVE = 1,
        IDX_END    = 2
    } state_idx_e;

    // The length field sits directly above the right-aligned data field.
    function automatic int entry_len_lsb(input int data_len);
        return data_len;
    endfunction

endpackage

// File: rtl/spi_rx_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Single-clock first-word-fall-through FIFO. Storage is an inferred RAM with
// a registered read port; the registered read is made look-ahead so the head
// entry is visible on rd_data in the same cycle rd_vld rises.
//
// Ports:
//   clk      in   clock
//   srst     in   synchronous active-high reset (flushes the FIFO)
//   wr_en    in   write request; ignored while full
//   wr_data  in   WIDTH  entry to write
//   full     out  FIFO holds DEPTH entries
//   rd_en    in   pop request; ignored while empty
//   rd_data  out  WIDTH  head entry, forced to 0 while empty
//   rd_vld   out  FIFO not empty
// ---------------------------------------------------------------------------
module sync_fifo
    import spi_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_reg;

    logic             wr_ok;
    logic             rd_ok;

    assign full   = (count_reg == CW'(DEPTH));
    assign rd_vld = (count_reg != '0);
    assign wr_ok  = wr_en && !full;
    assign rd_ok  = rd_en && rd_vld;

    // Pointer increments wrap explicitly so DEPTH need not be a power of two.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_ok) begin
            wr_ptr_next = (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_next = (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Look-ahead read: fetch the entry that will be at the head next cycle.
    // When that slot is being written in this same cycle (FIFO empty, or
    // emptying by the concurrent pop) the RAM would return stale contents, so
    // the write data is forwarded instead.
    always_ff @(posedge clk) begin
        if (wr_ok && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= wr_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    // The head register is not reset; gating keeps the output at 0 when empty.
    assign rd_data = rd_vld ? head_reg : '0;

endmodule

// File: rtl/spi_rx.sv
// ---------------------------------------------------------------------------
// spi_rx
//
// Receive path of the SPI master (mode 0 only). While in RECV, each sampling
// strobe from the shared clock generator captures one bit of sdi_i. When the
// requested number of bits has arrived the word, tagged with its length, is
// pushed into a FIFO and offered upstream on a valid/ready interface.
//
// Ports:
//   clk_i       in   controller clock
//   rst_i       in   synchronous active-high reset
//   rx_start_i  in   one-cycle request to receive a word (accepted in IDLE)
//   rx_len_i    in   DATA_VLD  word length minus one, sampled with rx_start_i
//   bit_en_i    in   sampling strobe, one clk_i cycle per SCK sampling edge
//   sdi_i       in   serial data in (MISO)
//   clk_en_o    out  asks the clock generator for SCK; high in RECV
//   busy_o      out  high whenever the FSM is not IDLE
//   rx_data_o   out  FIFO_WIDTH  FIFO head, {len, data}
//   rx_vld_o    out  FIFO not empty
//   rx_rdy_i    in   upstream takes the head word
//   ovf_o       out  pulses during the PUSH cycle of a word dropped on full
// ---------------------------------------------------------------------------
module spi_rx
    import spi_rx_pkg::*;
#(
    parameter int DLY        = 1,
    parameter int DATA_LEN   = DEFAULT_DATA_LEN,
    parameter int DATA_VLD   = $clog2(DATA_LEN),
    parameter int FIFO_WIDTH = DATA_LEN + DATA_VLD,
    parameter int FIFO_DEPTH = 16,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_start_i,
    input  logic [DATA_VLD-1:0]   rx_len_i,
    input  logic                  bit_en_i,
    input  logic                  sdi_i,
    output logic                  clk_en_o,
    output logic                  busy_o,
    output logic [FIFO_WIDTH-1:0] rx_data_o,
    output logic                  rx_vld_o,
    input  logic                  rx_rdy_i,
    output logic                  ovf_o
);

    localparam int LEN_LSB = entry_len_lsb(DATA_LEN);

    // DLY only matters to behavioural models of this block; the RTL is
    // zero-delay, so the parameter is accepted and otherwise has no effect.
    if (DLY < 0) begin : g_dly_negative
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    logic [DATA_VLD-1:0]   len_reg;
    logic [DATA_VLD-1:0]   len_next;
    logic [DATA_VLD-1:0]   cnt_reg;
    logic [DATA_VLD-1:0]   cnt_next;
    logic [DATA_LEN-1:0]   shift_reg;
    logic [DATA_LEN-1:0]   shift_next;

    // Shift register contents after capturing sdi_i on the current strobe
    logic [DATA_LEN-1:0]   shift_captured;

    logic                  in_recv;
    logic                  in_push;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic [FIFO_WIDTH-1:0] fifo_entry;

    assign in_recv = (state_reg == ST_RECV);
    assign in_push = (state_reg == ST_PUSH);

    // -----------------------------------------------------------------------
    // Bit capture. MSB-first shifts left so the first bit ends up at bit
    // len; LSB-first writes bit cnt directly. Both leave the word
    // right-aligned with zeros above len because the register is cleared on
    // start.
    // -----------------------------------------------------------------------
    if (MSB_FIRST) begin : g_msb_first
        assign shift_captured = {shift_reg[DATA_LEN-2:0], sdi_i};
    end else begin : g_lsb_first
        for (genvar gi = 0; gi < DATA_LEN; gi++) begin : g_bit
            assign shift_captured[gi] = (cnt_reg == DATA_VLD'(gi)) ? sdi_i
                                                                  : shift_reg[gi];
        end
    end

    // -----------------------------------------------------------------------
    // FSM and datapath next-state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rx_start_i) begin
                    len_next   = rx_len_i;
                    cnt_next   = '0;
                    shift_next = '0;
                    state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (bit_en_i) begin
                    shift_next = shift_captured;
                    // Compare happens on the pre-increment value, so a full
                    // DATA_LEN word ends before the counter would wrap.
                    cnt_next   = cnt_reg + DATA_VLD'(1);
                    if (cnt_reg == len_reg) begin
                        state_next = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            cnt_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO write. Fullness is taken before any concurrent pop, so a word
    // completing while the FIFO is full is dropped even if upstream pops in
    // the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        fifo_entry                          = '0;
        fifo_entry[DATA_LEN-1:0]            = shift_reg;
        fifo_entry[LEN_LSB +: DATA_VLD]     = len_reg;
    end

    assign fifo_wr = in_push && !fifo_full;
    assign ovf_o   = in_push && fifo_full;

    sync_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .srst    (rst_i),
        .wr_en   (fifo_wr),
        .wr_data (fifo_entry),
        .full    (fifo_full),
        .rd_en   (rx_rdy_i),
        .rd_data (rx_data_o),
        .rd_vld  (rx_vld_o)
    );

    // -----------------------------------------------------------------------
    // Status outputs
    // -----------------------------------------------------------------------
    assign clk_en_o = in_recv;
    assign busy_o   = (state_reg != ST_IDLE);

endmodule
